// File: rtl/counter_sequence_checker_if.sv
// rtl/counter_sequence_checker_if.sv - sample/status bundle between a counter bench and the sequence checker
interface counter_sequence_checker_if #(
   parameter int WIDTH = 4
);
   logic             sample_en;
   logic [WIDTH-1:0] q_in;
   logic             locked;
   logic             err;
   logic [7:0]       err_count;
   logic [WIDTH-1:0] expected;

   modport master (
      output sample_en, q_in,
      input  locked, err, err_count, expected
   );

   modport slave (
      input  sample_en, q_in,
      output locked, err, err_count, expected
   );
endinterface

// File: rtl/counter_sequence_checker.sv
// rtl/counter_sequence_checker.sv - locks onto a modulo-2^WIDTH counter sequence and counts breaks
// Optional macro CHECKER_HOLD_EN: a repeat of the previous sample is ignored instead of treated as a break.
module counter_sequence_checker #(
   parameter int WIDTH    = 4,
   parameter bit DOWN     = 1'b0,
   parameter int LOCK_CNT = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   counter_sequence_checker_if.slave     bus
);
   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
   localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_CNT);

   state_t           state, state_next;
   logic [3:0]       match_cnt, match_next;
   logic [WIDTH-1:0] exp_q, exp_next;
   logic             err_q, err_next;
   logic [7:0]       cnt_q, cnt_next;

   logic [WIDTH-1:0] stepped;
   logic             hit;
   logic             hold;

   assign stepped = DOWN ? (bus.q_in - ONE) : (bus.q_in + ONE);
   assign hit     = (bus.q_in == exp_q);

`ifdef CHECKER_HOLD_EN
   // The previous sample is exactly one step behind the prediction.
   logic [WIDTH-1:0] prev;
   assign prev = DOWN ? (exp_q + ONE) : (exp_q - ONE);
   assign hold = (state != IDLE) && (bus.q_in == prev);
`else
   assign hold = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         match_cnt <= 4'd0;
         exp_q     <= '0;
         err_q     <= 1'b0;
         cnt_q     <= 8'd0;
      end else begin
         state     <= state_next;
         match_cnt <= match_next;
         exp_q     <= exp_next;
         err_q     <= err_next;
         cnt_q     <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      match_next = match_cnt;
      exp_next   = exp_q;
      err_next   = 1'b0;
      cnt_next   = cnt_q;
      if (bus.sample_en && !hold) begin
         // Always resync the prediction to what was actually observed.
         exp_next = stepped;
         case (state)
            IDLE: begin
               match_next = 4'd0;
               state_next = ACQUIRE;
            end
            ACQUIRE: begin
               if (hit) begin
                  match_next = match_cnt + 4'd1;
                  if (match_cnt + 4'd1 == LOCK_TARGET)
                     state_next = LOCKED;
               end else begin
                  match_next = 4'd0;
               end
            end
            LOCKED: begin
               if (!hit) begin
                  err_next   = 1'b1;
                  match_next = 4'd0;
                  state_next = ACQUIRE;
                  if (cnt_q != 8'hFF)
                     cnt_next = cnt_q + 8'd1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.locked    = (state == LOCKED);
      bus.err       = err_q;
      bus.err_count = cnt_q;
      bus.expected  = exp_q;
   end
endmodule

// File: tb/tb_counter_sequence_checker.sv
// tb/tb_counter_sequence_checker.sv - scoreboard bench for an up and a down counter_sequence_checker
module tb_counter_sequence_checker;
   typedef struct {
      string      tag;
      logic       locked;
      logic       err;
      logic [7:0] cnt;
      logic [3:0] exp;
   } resp_t;

   logic clk;
   logic rst_up, rst_dn;
   int   checks = 0;
   int   errors = 0;
   resp_t q_up[$];
   resp_t q_dn[$];

   counter_sequence_checker_if #(.WIDTH(4)) if_up ();
   counter_sequence_checker_if #(.WIDTH(4)) if_dn ();

   counter_sequence_checker #(.WIDTH(4), .DOWN(1'b0), .LOCK_CNT(3)) dut_up (
      .clk (clk),
      .rst (rst_up),
      .bus (if_up.slave)
   );

   counter_sequence_checker #(.WIDTH(4), .DOWN(1'b1), .LOCK_CNT(3)) dut_dn (
      .clk (clk),
      .rst (rst_dn),
      .bus (if_dn.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic resp_t mk(input string tag, input logic l, input logic e,
                                input logic [7:0] c, input logic [3:0] x);
      resp_t r;
      r.tag = tag; r.locked = l; r.err = e; r.cnt = c; r.exp = x;
      return r;
   endfunction

   task automatic compare(input resp_t e, input logic l, input logic er,
                          input logic [7:0] c, input logic [3:0] x);
      checks++;
      if (l !== e.locked || er !== e.err || c !== e.cnt || x !== e.exp) begin
         errors++;
         $display("FAIL %s: got locked=%b err=%b err_count=%h expected=%h, want locked=%b err=%b err_count=%h expected=%h",
                  e.tag, l, er, c, x, e.locked, e.err, e.cnt, e.exp);
      end
   endtask

   // One clock of stimulus for the selected DUT, with its expected registered response.
   task automatic cyc(input bit dn, input logic r, input logic en, input logic [3:0] q, input resp_t e);
      if (dn) begin
         rst_dn = r; if_dn.sample_en = en; if_dn.q_in = q; q_dn.push_back(e);
      end else begin
         rst_up = r; if_up.sample_en = en; if_up.q_in = q; q_up.push_back(e);
      end
      @(negedge clk);
      rst_up = 1'b0; rst_dn = 1'b0; if_up.sample_en = 1'b0; if_dn.sample_en = 1'b0;
   endtask

   initial begin
      resp_t e;
      forever begin
         @(posedge clk);
         if (q_up.size() > 0) begin
            @(negedge clk);
            e = q_up.pop_front();
            compare(e, if_up.locked, if_up.err, if_up.err_count, if_up.expected);
         end
      end
   end

   initial begin
      resp_t e;
      forever begin
         @(posedge clk);
         if (q_dn.size() > 0) begin
            @(negedge clk);
            e = q_dn.pop_front();
            compare(e, if_dn.locked, if_dn.err, if_dn.err_count, if_dn.expected);
         end
      end
   end

   initial begin
      logic [3:0] v;
      logic [7:0] c;
      int         wait_cycles;
      rst_up = 1'b0; rst_dn = 1'b0;
      if_up.sample_en = 1'b0; if_up.q_in = 4'h0;
      if_dn.sample_en = 1'b0; if_dn.q_in = 4'h0;

      cyc(0, 1, 1, 4'h7, mk("up_reset", 0, 0, 8'h00, 4'h0));
      cyc(1, 1, 1, 4'h7, mk("dn_reset", 0, 0, 8'h00, 4'h0));

      cyc(0, 0, 1, 4'hE, mk("t1_first", 0, 0, 8'h00, 4'hF));
      cyc(0, 0, 1, 4'hF, mk("t1_m1", 0, 0, 8'h00, 4'h0));
      cyc(0, 0, 1, 4'h0, mk("t1_wrap", 0, 0, 8'h00, 4'h1));
      cyc(0, 0, 1, 4'h1, mk("t1_lock", 1, 0, 8'h00, 4'h2));
      cyc(0, 0, 0, 4'h9, mk("t1_idle", 1, 0, 8'h00, 4'h2));

      cyc(0, 0, 1, 4'h5, mk("t2_break", 0, 1, 8'h01, 4'h6));
      cyc(0, 0, 1, 4'h6, mk("t2_m1", 0, 0, 8'h01, 4'h7));
      cyc(0, 0, 1, 4'h7, mk("t2_m2", 0, 0, 8'h01, 4'h8));
      cyc(0, 0, 1, 4'h8, mk("t2_relock", 1, 0, 8'h01, 4'h9));

      cyc(0, 0, 1, 4'h9, mk("t4_step", 1, 0, 8'h01, 4'hA));
`ifdef CHECKER_HOLD_EN
      cyc(0, 0, 1, 4'h9, mk("t4_hold", 1, 0, 8'h01, 4'hA));
      cyc(0, 0, 1, 4'hA, mk("t4_a", 1, 0, 8'h01, 4'hB));
      cyc(0, 0, 1, 4'hB, mk("t4_b", 1, 0, 8'h01, 4'hC));
      cyc(0, 0, 1, 4'hC, mk("t4_c", 1, 0, 8'h01, 4'hD));
`else
      cyc(0, 0, 1, 4'h9, mk("t4_repeat", 0, 1, 8'h02, 4'hA));
      cyc(0, 0, 1, 4'hA, mk("t4_a", 0, 0, 8'h02, 4'hB));
      cyc(0, 0, 1, 4'hB, mk("t4_b", 0, 0, 8'h02, 4'hC));
      cyc(0, 0, 1, 4'hC, mk("t4_c", 1, 0, 8'h02, 4'hD));
`endif

      cyc(0, 1, 1, 4'h3, mk("t5_rst_locked", 0, 0, 8'h00, 4'h0));
      cyc(0, 0, 1, 4'h7, mk("t5_first_bad", 0, 0, 8'h00, 4'h8));

      cyc(1, 0, 1, 4'h1, mk("t3_first", 0, 0, 8'h00, 4'h0));
      cyc(1, 0, 1, 4'h0, mk("t3_m1", 0, 0, 8'h00, 4'hF));
      cyc(1, 0, 1, 4'hF, mk("t3_wrap", 0, 0, 8'h00, 4'hE));
      cyc(1, 0, 1, 4'hE, mk("t3_lock", 1, 0, 8'h00, 4'hD));
      cyc(1, 0, 1, 4'h3, mk("t3_break", 0, 1, 8'h01, 4'h2));

      cyc(0, 0, 1, 4'h8, mk("t6_m1", 0, 0, 8'h00, 4'h9));
      cyc(0, 0, 1, 4'h9, mk("t6_m2", 0, 0, 8'h00, 4'hA));
      cyc(0, 0, 1, 4'hA, mk("t6_lock", 1, 0, 8'h00, 4'hB));
      v = 4'hA;
      for (int i = 1; i <= 300; i++) begin
         c = (i > 255) ? 8'hFF : 8'(i);
         cyc(0, 0, 1, v + 4'd5, mk($sformatf("t6_break%0d", i), 0, 1, c, v + 4'd6));
         cyc(0, 0, 1, v + 4'd6, mk("t6_r1", 0, 0, c, v + 4'd7));
         cyc(0, 0, 1, v + 4'd7, mk("t6_r2", 0, 0, c, v + 4'd8));
         cyc(0, 0, 1, v + 4'd8, mk("t6_relock", 1, 0, c, v + 4'd9));
         v = v + 4'd8;
      end
      cyc(0, 0, 0, 4'h0, mk("t6_idle_sat", 1, 0, 8'hFF, v + 4'd1));

      wait_cycles = 0;
      while ((q_up.size() > 0 || q_dn.size() > 0) && wait_cycles < 20) begin
         @(negedge clk);
         wait_cycles++;
      end
      @(negedge clk);
      if (q_up.size() > 0 || q_dn.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d responses left, want 0", q_up.size() + q_dn.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
